// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one pipelined IEEE-754 double multiplier among N requesters.
// Optional multiplier watchdog is compiled in with FP_MULT_ARB_WATCHDOG_EN.
module fp_mult_arbiter #(
    parameter  int unsigned N       = 4,
    parameter  int unsigned IDXW    = $clog2(N),
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned DW      = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] op_a,
    input  logic [N*DW-1:0] op_b,
    output logic [N-1:0]    done,
    output logic [DW-1:0]   result,
    output logic            busy,
    output logic [IDXW-1:0] grant_idx,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    output logic            mul_start,
    output logic            mul_clr,
    input  logic [DW-1:0]   mul_result,
    input  logic            mul_done,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [IDXW-1:0] grant_idx_d;
    logic [DW-1:0]   mul_a_d, mul_b_d, result_d;
    logic [N-1:0]    done_d;
    logic            busy_d, mul_start_d, mul_clr_d;
    logic            pick_valid;
    logic [IDXW-1:0] pick_idx, cand;
    logic [DW-1:0]   op_a_arr [N];
    logic [DW-1:0]   op_b_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign op_a_arr[g] = op_a[g*DW +: DW];
        assign op_b_arr[g] = op_b[g*DW +: DW];
    end

`ifdef FP_MULT_ARB_WATCHDOG_EN
    localparam int unsigned  WDW  = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_err_d;
    logic           wd_expired;

    assign wd_expired = (wd_cnt_q == WDW'(TIMEOUT));
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT);
    assign timeout_err    = 1'b0;
`endif

    // Round-robin pick: first set request after the last grant, wrapping modulo N.
    always_comb begin : p_pick
        pick_valid = 1'b0;
        pick_idx   = last_q;
        cand       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDXW'((32'(last_q) + k) % N);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin : p_next
        state_d     = state_q;
        last_d      = last_q;
        grant_idx_d = grant_idx;
        mul_a_d     = mul_a;
        mul_b_d     = mul_b;
        result_d    = result;
`ifdef FP_MULT_ARB_WATCHDOG_EN
        wd_cnt_d      = '0;
        timeout_err_d = timeout_err;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    last_d      = pick_idx;
                    mul_a_d     = op_a_arr[pick_idx];
                    mul_b_d     = op_b_arr[pick_idx];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    result_d = mul_result;
                    state_d  = RESP;
                end
`ifdef FP_MULT_ARB_WATCHDOG_EN
                // Stuck multiplier: answer with a quiet NaN so the requester is not starved.
                else if (wd_expired) begin
                    result_d      = QNAN;
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        mul_start_d = (state_d == BUSY);
        mul_clr_d   = (state_d != BUSY);
        done_d      = '0;
        if (state_d == RESP) begin
            done_d[grant_idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin : p_state
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IDXW'(N - 1);
            grant_idx <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            result    <= '0;
            done      <= '0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_clr   <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_idx <= grant_idx_d;
            mul_a     <= mul_a_d;
            mul_b     <= mul_b_d;
            result    <= result_d;
            done      <= done_d;
            busy      <= busy_d;
            mul_start <= mul_start_d;
            mul_clr   <= mul_clr_d;
        end
    end

`ifdef FP_MULT_ARB_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin : p_watchdog
        if (reset) begin
            wd_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            timeout_err <= timeout_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter: random requesters, multiplier model and a
// round-robin/latency reference model derived from request history.
module tb_fp_mult_arbiter;

    localparam int N       = 4;
    localparam int IDXW    = 2;
    localparam int TIMEOUT = 64;
    localparam int L       = 5;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*64-1:0] op_a, op_b;
    logic [N-1:0]    done;
    logic [63:0]     result;
    logic            busy;
    logic [IDXW-1:0] grant_idx;
    logic [63:0]     mul_a, mul_b, mul_result;
    logic            mul_start, mul_clr, mul_done;
    logic            timeout_err;

    logic [63:0] opa_arr [N];
    logic [63:0] opb_arr [N];
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign op_a[g*64 +: 64] = opa_arr[g];
        assign op_b[g*64 +: 64] = opb_arr[g];
    end

    fp_mult_arbiter #(.N(N), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
        .done(done), .result(result), .busy(busy), .grant_idx(grant_idx),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_clr(mul_clr),
        .mul_result(mul_result), .mul_done(mul_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    function automatic logic [63:0] rand_dbl();
        real v;
        v = real'($urandom_range(1, 4000)) / 16.0;
        if ($urandom_range(0, 1) == 1) v = -v;
        return $realtobits(v);
    endfunction

    // Multiplier model: product valid after L+1 cycles of start; stray done pulses while idle.
    int   mcnt = 0;
    int   cyc  = 0;
    logic stray = 1'b0;
    logic mul_hang = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_clr) mcnt <= 0;
        else if (mul_start) mcnt <= mcnt + 1;
        stray <= ($urandom_range(0, 7) == 0);
    end
    assign mul_done   = (mul_start && !mul_hang && mcnt == L) || (!mul_start && stray);
    assign mul_result = fmul(mul_a, mul_b);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    logic [N-1:0] req_hist [int];
    logic [63:0]  ref_a [N];
    logic [63:0]  ref_b [N];
    logic [N-1:0] pending;
    int           last_ref;
    int           grant_log [$];
    int           done_log  [$];
    logic         gen_en;
    int           rate;

    task automatic monitor();
        int           gc, eg, lat, c;
        logic [N-1:0] set;
        forever begin
            @(negedge clk);
            req_hist[cyc] = req;
            check("start_clr_excl", 64'(mul_start & mul_clr), 64'd0);
            if (done != '0) begin
                lat = mul_hang ? TIMEOUT : L;
                gc  = cyc - 2 - lat;
                set = req_hist.exists(gc) ? req_hist[gc] : '0;
                eg  = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (last_ref + k) % N;
                    if (eg < 0 && set[IDXW'(c)]) eg = c;
                end
                check("grant_idx", 64'(grant_idx), 64'(eg));
                if (eg >= 0) begin
                    check("done_vec", 64'(done), 64'(1) << eg);
                    check("pending", 64'(pending[IDXW'(eg)]), 64'd1);
                    check("result", result,
                          mul_hang ? QNAN : fmul(ref_a[IDXW'(eg)], ref_b[IDXW'(eg)]));
                    pending[IDXW'(eg)] = 1'b0;
                    last_ref = eg;
                    grant_log.push_back(eg);
                    done_log.push_back(cyc);
                end
            end
        end
    endtask

    task automatic raise_ops(input int i, input logic [63:0] a, input logic [63:0] b);
        ref_a[IDXW'(i)]   = a;
        ref_b[IDXW'(i)]   = b;
        opa_arr[IDXW'(i)] = a;
        opb_arr[IDXW'(i)] = b;
        req[IDXW'(i)]     = 1'b1;
        pending[IDXW'(i)] = 1'b1;
    endtask

    // One clock: requesters drop req on their done, optionally raise new random requests.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req[IDXW'(i)] && done[IDXW'(i)]) begin
                req[IDXW'(i)] = 1'b0;
            end else if (!req[IDXW'(i)] && !pending[IDXW'(i)] && gen_en &&
                         $urandom_range(0, 99) < rate) begin
                raise_ops(i, rand_dbl(), rand_dbl());
            end
        end
    endtask

    task automatic do_reset();
        step();
        reset    = 1'b1;
        req      = '0;
        pending  = '0;
        last_ref = N - 1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((pending != '0 || req != '0) && n < bound) begin
            step();
            n++;
        end
        check("drain", 64'(pending), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant"}, 64'(grant_idx), 64'd0);
        check({tag, "_mul_a"}, mul_a, 64'd0);
        check({tag, "_mul_b"}, mul_b, 64'd0);
        check({tag, "_start"}, 64'(mul_start), 64'd0);
        check({tag, "_clr"}, 64'(mul_clr), 64'd1);
        check({tag, "_tmo"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin
        int          c0, base, guard;
        logic [63:0] a_sv, b_sv;

        reset    = 1'b1;
        req      = '0;
        pending  = '0;
        last_ref = N - 1;
        gen_en   = 1'b0;
        rate     = 0;
        for (int i = 0; i < N; i++) begin
            opa_arr[IDXW'(i)] = '0;
            opb_arr[IDXW'(i)] = '0;
        end
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_result", result, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single op latency and busy window
        step();
        c0 = cyc;
        raise_ops(0, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        for (int d = 0; d <= 9; d++) begin
            check("t1_busy", 64'(busy), 64'(d >= 1 && d <= 7));
            check("t1_done", 64'(done[0]), 64'(d == 7));
            if (d == 7) begin
                check("t1_result", result, 64'h4018_0000_0000_0000);
                check("t1_grant", 64'(grant_idx), 64'd0);
            end
            step();
        end
        check("t1_cycle", 64'(cyc - c0), 64'd10);

        // Contention 0,1,3 after reset
        do_reset();
        base = grant_log.size();
        step();
        raise_ops(0, rand_dbl(), rand_dbl());
        raise_ops(1, rand_dbl(), rand_dbl());
        raise_ops(3, rand_dbl(), rand_dbl());
        wait_drain(100);
        check("t2_count", 64'(grant_log.size() - base), 64'd3);
        if (grant_log.size() >= base + 3) begin
            check("t2_order0", 64'(grant_log[base]), 64'd0);
            check("t2_order1", 64'(grant_log[base + 1]), 64'd1);
            check("t2_order2", 64'(grant_log[base + 2]), 64'd3);
        end

        // Fairness with permanently re-raised requests
        do_reset();
        base   = grant_log.size();
        gen_en = 1'b1;
        rate   = 100;
        guard  = 0;
        while (grant_log.size() < base + 8 && guard < 200) begin
            step();
            guard++;
        end
        gen_en = 1'b0;
        check("t3_ops", 64'(grant_log.size() >= base + 8), 64'd1);
        wait_drain(100);
        if (grant_log.size() >= base + 8) begin
            for (int k = 0; k < 8; k++)
                check("t3_order", 64'(grant_log[base + k]), 64'(k % N));
            for (int k = 1; k < 8; k++)
                check("t3_spacing", 64'(done_log[base + k] - done_log[base + k - 1]), 64'(3 + L));
        end

        // Reset mid-operation
        do_reset();
        base = grant_log.size();
        step();
        raise_ops(1, rand_dbl(), rand_dbl());
        repeat (3) step();
        check("t4_busy_pre", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("t4");
        req      = '0;
        pending  = '0;
        last_ref = N - 1;
        step();
        step();
        reset = 1'b0;
        repeat (8) step();
        check("t4_no_done", 64'(grant_log.size()), 64'(base));
        raise_ops(2, rand_dbl(), rand_dbl());
        wait_drain(100);
        check("t4_grant2", 64'(grant_log.size() == base + 1 ? grant_log[base] : -1), 64'd2);

        // Requester drops req mid-operation and scribbles its operands
        do_reset();
        step();
        c0   = cyc;
        a_sv = rand_dbl();
        b_sv = rand_dbl();
        raise_ops(1, a_sv, b_sv);
        for (int d = 0; d <= 9; d++) begin
            if (d == 3) begin
                req[1]     = 1'b0;
                opa_arr[1] = rand_dbl();
                opb_arr[1] = 64'h4000_0000_0000_0000;
            end
            if (d == 5) check("t5_mul_a", mul_a, a_sv);
            check("t5_done", 64'(done[1]), 64'(d == 7));
            if (d == 7) check("t5_result", result, fmul(a_sv, b_sv));
            if (d == 8) check("t5_idle", 64'(busy), 64'd0);
            step();
        end
        check("t5_cycle", 64'(cyc - c0), 64'd10);

        // Random traffic
        gen_en = 1'b1;
        rate   = 25;
        repeat (500) step();
        gen_en = 1'b0;
        wait_drain(200);

`ifdef FP_MULT_ARB_WATCHDOG_EN
        // Watchdog: multiplier never answers
        do_reset();
        mul_hang = 1'b1;
        step();
        c0 = cyc;
        raise_ops(3, rand_dbl(), rand_dbl());
        for (int d = 0; d <= 68; d++) begin
            check("t6_done", 64'(done[3]), 64'(d == 66));
            if (d == 65) check("t6_tmo_pre", 64'(timeout_err), 64'd0);
            if (d == 66) begin
                check("t6_result", result, QNAN);
                check("t6_tmo", 64'(timeout_err), 64'd1);
            end
            step();
        end
        mul_hang = 1'b0;
        raise_ops(0, rand_dbl(), rand_dbl());
        wait_drain(100);
        check("t6_sticky", 64'(timeout_err), 64'd1);
        do_reset();
        check("t6_cleared", 64'(timeout_err), 64'd0);
`else
        check("tmo_tied", 64'(timeout_err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one pipelined IEEE-754 double multiplier between N requesters using round-robin arbitration.
- Requesters are the kinematics function blocks (x², y², l1·l2, 2·l1l2, final scaling, and so on); each uses its own req/done handshake.
- Sequences the multiplier's start/clear protocol and returns the product on a shared result bus, tagged by a per-requester done pulse.
- Replaces hand-written per-module multiplier-sharing state machines.

Parameters:
- N, 4, number of requesters (2..8).
- IDXW, $clog2(N), width of the granted-index field.
- TIMEOUT, 64, watchdog limit in cycles (used only with FP_MULT_ARB_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  N  per-requester request; level, held until that requester's done
- op_a  in  N*64  operand A; requester i occupies bits [64i+63:64i]
- op_b  in  N*64  operand B, same packing as op_a
- done  out  N  one-cycle pulse to the granted requester; result is valid in the same cycle
- result  out  64  product register, shared by all requesters
- busy  out  1  high in every state except IDLE
- grant_idx  out  IDXW  index of the current or last granted requester
- mul_a  out  64  registered operand A to the multiplier
- mul_b  out  64  registered operand B to the multiplier
- mul_start  out  1  multiplier in_ready; level, held high during BUSY
- mul_clr  out  1  multiplier synchronous reset; high in IDLE and RESP
- mul_result  in  64  multiplier product
- mul_done  in  1  multiplier data_ready
- timeout_err  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out

Behaviour:
Reset:
- Asynchronous reset forces state=IDLE, done=0, result=0, busy=0, grant_idx=0, mul_a=0, mul_b=0, mul_start=0, mul_clr=1, timeout_err=0.
- Round-robin pointer last=N-1, so requester 0 has top priority after reset.

States:
- IDLE:
  - mul_clr=1.
  - If any req is set, select the first set bit scanning last+1, last+2, ... with wrap modulo N.
  - On that edge: latch grant_idx, mul_a=op_a[idx], mul_b=op_b[idx]; set last=idx; go to BUSY.
- BUSY:
  - mul_start=1, mul_clr=0. Operands are frozen; op_a/op_b changes are ignored.
  - On mul_done=1: result<=mul_result, go to RESP.
- RESP (exactly one cycle):
  - done[grant_idx]=1, mul_clr=1, mul_start=0; then go to IDLE.
  - req[grant_idx] is masked this cycle.

Timing:
- From an idle arbiter: req rises in cycle 0, BUSY starts in cycle 1, mul_done arrives in cycle 1+L, done pulses in cycle 2+L.
- Back-to-back grants: minimum 3+L cycles per operation (IDLE, BUSY×(L+1), RESP).

Requester and multiplier rules:
- A requester deasserts req in the cycle after its done pulse. If req is still high in IDLE, it is treated as a new request.
- Dropping req mid-operation does not abort the operation; the done pulse is still issued.
- mul_done seen outside BUSY is ignored.

Arbitration:
- Simultaneous requests are served in round-robin order. No requester waits more than N−1 grants.

Reset mid-operation:
- Reset during BUSY or RESP aborts immediately; no done pulse is issued.
- The multiplier is cleared by mul_clr=1.

Optional Feature:
FP_MULT_ARB_WATCHDOG_EN:
- Defined:
  - A cycle counter runs in BUSY.
  - If it reaches TIMEOUT with no mul_done: set timeout_err (sticky until reset), result=64'h7FF8_0000_0000_0000 (quiet NaN), go to RESP so the requester still receives done.
- Undefined:
  - No counter; BUSY waits for mul_done indefinitely.
  - timeout_err is tied to 0.

Test Plan:
1. Single op: req[0]=1, op_a[0]=2.0 (0x4000000000000000), op_b[0]=3.0, model L=5 → done[0] pulses exactly 7 cycles after req; result=6.0 (0x4018000000000000); grant_idx=0; busy high for cycles 1..7.
2. Contention: req=4'b1011 asserted together, each requester drops req after its done → done order 0,1,3; each result matches its own operands; no cycle where mul_start=1 and mul_clr=1 together.
3. Fairness: all four req held permanently (re-raised after each done) → grant sequence 0,1,2,3,0,1…; 8 operations spaced 3+L cycles apart.
4. Reset mid-op: assert reset during BUSY → outputs reach reset values asynchronously; no done pulse; after release, req[2] is granted normally and returns a correct result.
5. Dropped req: req[1] deasserted during BUSY → done[1] still pulses; result is correct; arbiter returns to IDLE.
6. Watchdog (macro defined, TIMEOUT=64): model never raises mul_done → done pulses 65 cycles after BUSY entry; result=0x7FF8000000000000; timeout_err=1 and stays set until reset.
